// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the memory fetch port.
// Hits answer one cycle after the request; misses fetch from memory, fill the line, then answer.
module icache_direct #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_HI     = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        fetch_start,
  input  logic [31:0] pc,
  output logic        finish_fetch,
  output logic [31:0] instruction_out,
  output logic [31:0] instruction_pc_out,
  output logic        mem_fetch_start,
  output logic [31:0] mem_pc,
  input  logic        mem_finish_fetch,
  input  logic [31:0] mem_instruction,
  output logic        is_idle,
  output logic        state_dbg_o
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_HI - INDEX_WIDTH - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  state_e                   state_q;
  logic [LINES-1:0]         valid_q;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [31:0]              data_q [LINES];
  logic                     finish_q;
  logic [31:0]              instr_q;
  logic [31:0]              ipc_q;
  logic                     mem_start_q;
  logic [31:0]              mem_pc_q;

  logic [INDEX_WIDTH-1:0]   req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [INDEX_WIDTH-1:0]   fill_idx;
  logic [TAG_W-1:0]         fill_tag;
  logic                     req_hit;
  logic                     fill_en;
  logic                     unused_pc_bits;

  assign req_idx  = pc[INDEX_WIDTH+1:2];
  assign req_tag  = pc[ADDR_HI:INDEX_WIDTH+2];
  // mem_pc_q doubles as the latched miss address; the fill uses its fields.
  assign fill_idx = mem_pc_q[INDEX_WIDTH+1:2];
  assign fill_tag = mem_pc_q[ADDR_HI:INDEX_WIDTH+2];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_en  = rdy_in && !roll_back && (state_q == S_MISS) && mem_finish_fetch;
  assign unused_pc_bits = ^{pc[31:ADDR_HI+1], pc[1:0]};

  // Handshake: fetch_start is a 1-cycle request accepted only in IDLE with no answer pending;
  // mem_fetch_start stays high with mem_pc stable until a mem_finish_fetch pulse;
  // finish_fetch is a 1-cycle answer; roll_back cancels both sides; rdy_in=0 freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      finish_q    <= 1'b0;
      instr_q     <= '0;
      ipc_q       <= '0;
      mem_start_q <= 1'b0;
      mem_pc_q    <= '0;
    end else if (rdy_in) begin
      finish_q <= 1'b0;
      if (roll_back) begin
        state_q     <= S_IDLE;
        mem_start_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Holding off while an answer is still on the outputs keeps finish_fetch single-cycle.
            if (fetch_start && !finish_q) begin
              if (req_hit) begin
                finish_q <= 1'b1;
                instr_q  <= data_q[req_idx];
                ipc_q    <= pc;
              end else begin
                mem_start_q <= 1'b1;
                mem_pc_q    <= pc;
                state_q     <= S_MISS;
              end
            end
          end
          S_MISS: begin
            if (mem_finish_fetch) begin
              valid_q[fill_idx] <= 1'b1;
              finish_q          <= 1'b1;
              instr_q           <= mem_instruction;
              ipc_q             <= mem_pc_q;
              mem_start_q       <= 1'b0;
              state_q           <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits gate every use.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_instruction;
    end
  end

  assign finish_fetch       = finish_q;
  assign instruction_out    = instr_q;
  assign instruction_pc_out = ipc_q;
  assign mem_fetch_start    = mem_start_q;
  assign mem_pc             = mem_pc_q;
  assign is_idle            = (state_q == S_IDLE) && !mem_start_q;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus random fetch streams
// checked against a line-addressed cache model and a scripted memory responder.
module tb_icache_direct;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        fetch_start;
  logic [31:0] pc;
  logic        finish_fetch;
  logic [31:0] instruction_out;
  logic [31:0] instruction_pc_out;
  logic        mem_fetch_start;
  logic [31:0] mem_pc;
  logic        mem_finish_fetch;
  logic [31:0] mem_instruction;
  logic        is_idle;
  logic        state_dbg_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a line is identified by word address mod 256; it remembers the
  // full pc that filled it and the word. Hit iff pc bits [17:2] match.
  logic [31:0] cached_pc   [int];
  logic [31:0] cached_word [int];

  icache_direct dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .roll_back          (roll_back),
    .fetch_start        (fetch_start),
    .pc                 (pc),
    .finish_fetch       (finish_fetch),
    .instruction_out    (instruction_out),
    .instruction_pc_out (instruction_pc_out),
    .mem_fetch_start    (mem_fetch_start),
    .mem_pc             (mem_pc),
    .mem_finish_fetch   (mem_finish_fetch),
    .mem_instruction    (mem_instruction),
    .is_idle            (is_idle),
    .state_dbg_o        (state_dbg_o)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int l;
    l = line_of(a);
    if (!cached_pc.exists(l)) return 1'b0;
    return ((cached_pc[l] ^ a) & 32'h0003_FFFC) == 32'h0;
  endfunction

  task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
    cached_pc[line_of(a)]   = a;
    cached_word[line_of(a)] = d;
  endtask

  // Driver: issue one fetch, answer a memory request after lat cycles with d, report what was seen.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int lat,
                          output int fin_lat, output logic [31:0] ins, output logic [31:0] ipc,
                          output bit mem_req, output logic [31:0] mpc, output bit hold_ok,
                          output bit extra);
    int mc;
    fin_lat = -1; ins = '0; ipc = '0; mem_req = 0; mpc = '0; hold_ok = 1; extra = 0; mc = 0;
    @(negedge clk_in);
    fetch_start = 1'b1;
    pc = a;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_in);
      fetch_start = 1'b0;
      mem_finish_fetch = 1'b0;
      if (finish_fetch) begin
        fin_lat = c;
        ins = instruction_out;
        ipc = instruction_pc_out;
        if (mem_fetch_start) hold_ok = 0;
        break;
      end
      if (mem_fetch_start) begin
        if (!mem_req) mpc = mem_pc;
        else if (mem_pc !== mpc) hold_ok = 0;
        mem_req = 1;
        mc++;
        if (mc == lat) begin
          mem_finish_fetch = 1'b1;
          mem_instruction = d;
        end
      end
    end
    mem_finish_fetch = 1'b0;
    if (fin_lat > 0) begin
      @(negedge clk_in);
      extra = finish_fetch;
    end
  endtask

  task automatic apply_reset();
    rdy_in = 1'b1; roll_back = 1'b0; fetch_start = 1'b0; pc = '0;
    mem_finish_fetch = 1'b0; mem_instruction = '0;
    rst_in = 1'b0;
    cached_pc.delete();
    cached_word.delete();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (finish_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_finish got=%b exp=0", finish_fetch); end
    n_tests++; if (mem_fetch_start !== 1'b0) begin n_fail++; $display("FAIL reset_mem_start got=%b exp=0", mem_fetch_start); end
    n_tests++; if (instruction_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instruction_out); end
    n_tests++; if (instruction_pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_ipc got=%h exp=0", instruction_pc_out); end
    n_tests++; if (mem_pc !== 32'h0) begin n_fail++; $display("FAIL reset_mem_pc got=%h exp=0", mem_pc); end
    n_tests++; if (is_idle !== 1'b1) begin n_fail++; $display("FAIL reset_is_idle got=%b exp=1", is_idle); end
  endtask

  task automatic test_miss_then_hit();
    int fl; logic [31:0] ins, ipc, mpc; bit mr, hold, ex;
    do_fetch(32'h10, 32'h13, 3, fl, ins, ipc, mr, mpc, hold, ex);
    model_fill(32'h10, 32'h13);
    n_tests++; if (mr !== 1'b1 || mpc !== 32'h10) begin n_fail++; $display("FAIL miss_request got_req=%b mem_pc=%h exp_req=1 mem_pc=00000010", mr, mpc); end
    n_tests++; if (fl != 4) begin n_fail++; $display("FAIL miss_latency got=%0d exp=4", fl); end
    n_tests++; if (ins !== 32'h13 || ipc !== 32'h10) begin n_fail++; $display("FAIL miss_data got=%h@%h exp=00000013@00000010", ins, ipc); end
    n_tests++; if (!hold || ex) begin n_fail++; $display("FAIL miss_hold_pulse hold_ok=%b extra=%b exp 1/0", hold, ex); end
    n_tests++; if (is_idle !== 1'b1) begin n_fail++; $display("FAIL miss_idle_after got=%b exp=1", is_idle); end
    do_fetch(32'h10, 32'hBAD0_0000, 3, fl, ins, ipc, mr, mpc, hold, ex);
    n_tests++; if (fl != 1 || mr !== 1'b0) begin n_fail++; $display("FAIL hit_latency got=%0d mem_req=%b exp=1/0", fl, mr); end
    n_tests++; if (ins !== 32'h13 || ipc !== 32'h10) begin n_fail++; $display("FAIL hit_data got=%h@%h exp=00000013@00000010", ins, ipc); end
  endtask

  task automatic test_conflict();
    int fl; logic [31:0] ins, ipc, mpc; bit mr, hold, ex, exp_hit;
    logic [31:0] seq_pc [3];
    logic [31:0] seq_d  [3];
    seq_pc[0] = 32'h410; seq_d[0] = 32'h93;
    seq_pc[1] = 32'h10;  seq_d[1] = 32'h0013_0013;
    seq_pc[2] = 32'h10;  seq_d[2] = 32'hBAD0_0001;
    for (int i = 0; i < 3; i++) begin
      exp_hit = model_hit(seq_pc[i]);
      do_fetch(seq_pc[i], seq_d[i], 2, fl, ins, ipc, mr, mpc, hold, ex);
      n_tests++;
      if (mr !== !exp_hit || fl != (exp_hit ? 1 : 3)) begin
        n_fail++; $display("FAIL conflict_%0d_kind got_req=%b lat=%0d exp_req=%b lat=%0d", i, mr, fl, !exp_hit, exp_hit ? 1 : 3);
      end
      if (!exp_hit) model_fill(seq_pc[i], seq_d[i]);
      n_tests++;
      if (ins !== cached_word[line_of(seq_pc[i])] || ipc !== seq_pc[i]) begin
        n_fail++; $display("FAIL conflict_%0d_data got=%h@%h exp=%h@%h", i, ins, ipc, cached_word[line_of(seq_pc[i])], seq_pc[i]);
      end
    end
  endtask

  task automatic test_roll_back();
    int fl; logic [31:0] ins, ipc, mpc; bit mr, hold, ex, seen;
    @(negedge clk_in); fetch_start = 1'b1; pc = 32'h20;
    @(negedge clk_in); fetch_start = 1'b0;
    n_tests++; if (mem_fetch_start !== 1'b1) begin n_fail++; $display("FAIL rb_miss_req got=%b exp=1", mem_fetch_start); end
    @(negedge clk_in); roll_back = 1'b1;
    @(negedge clk_in); roll_back = 1'b0;
    n_tests++; if (mem_fetch_start !== 1'b0 || is_idle !== 1'b1 || finish_fetch !== 1'b0) begin
      n_fail++; $display("FAIL rb_abort got mem_start=%b idle=%b finish=%b exp 0/1/0", mem_fetch_start, is_idle, finish_fetch);
    end
    mem_finish_fetch = 1'b1; mem_instruction = 32'hDEAD_BEEF;
    @(negedge clk_in); mem_finish_fetch = 1'b0;
    seen = finish_fetch;
    @(negedge clk_in); seen = seen | finish_fetch;
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rb_late_resp finish got=%b exp=0", seen); end
    do_fetch(32'h20, 32'h0020_0001, 2, fl, ins, ipc, mr, mpc, hold, ex);
    model_fill(32'h20, 32'h0020_0001);
    n_tests++; if (mr !== 1'b1 || ins !== 32'h0020_0001) begin n_fail++; $display("FAIL rb_refetch got_req=%b data=%h exp=1 00200001", mr, ins); end
    // Request in the same cycle as roll_back is dropped.
    @(negedge clk_in); fetch_start = 1'b1; pc = 32'h24; roll_back = 1'b1;
    @(negedge clk_in); fetch_start = 1'b0; roll_back = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | mem_fetch_start | finish_fetch;
      @(negedge clk_in);
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rb_same_cycle_fetch activity got=%b exp=0", seen); end
    // roll_back wins over a response arriving in the same cycle: no fill.
    @(negedge clk_in); fetch_start = 1'b1; pc = 32'h30;
    @(negedge clk_in); fetch_start = 1'b0;
    roll_back = 1'b1; mem_finish_fetch = 1'b1; mem_instruction = 32'h77;
    @(negedge clk_in); roll_back = 1'b0; mem_finish_fetch = 1'b0;
    n_tests++; if (finish_fetch !== 1'b0 || mem_fetch_start !== 1'b0) begin
      n_fail++; $display("FAIL rb_with_resp got finish=%b mem_start=%b exp 0/0", finish_fetch, mem_fetch_start);
    end
    do_fetch(32'h30, 32'h0030_0001, 1, fl, ins, ipc, mr, mpc, hold, ex);
    model_fill(32'h30, 32'h0030_0001);
    n_tests++; if (mr !== 1'b1 || fl != 2) begin n_fail++; $display("FAIL rb_no_fill got_req=%b lat=%0d exp=1/2", mr, fl); end
  endtask

  task automatic test_freeze();
    logic [31:0] exp_d;
    bit ok;
    exp_d = cached_word[line_of(32'h10)];
    // Whole pipeline frozen: IF keeps its request up while rdy_in is low.
    @(negedge clk_in); fetch_start = 1'b1; pc = 32'h10; rdy_in = 1'b0;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (finish_fetch !== 1'b0) ok = 0;
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL freeze_no_early_finish got early finish exp none"); end
    rdy_in = 1'b1;
    @(negedge clk_in); fetch_start = 1'b0;
    n_tests++; if (finish_fetch !== 1'b1 || instruction_out !== exp_d || instruction_pc_out !== 32'h10) begin
      n_fail++; $display("FAIL freeze_delayed_hit got=%b %h@%h exp=1 %h@00000010", finish_fetch, instruction_out, instruction_pc_out, exp_d);
    end
    // Pulse already on the outputs is held while frozen.
    rdy_in = 1'b0;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (finish_fetch !== 1'b1 || instruction_out !== exp_d || instruction_pc_out !== 32'h10) ok = 0;
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL freeze_hold_pulse got=%b %h exp=1 %h", finish_fetch, instruction_out, exp_d); end
    rdy_in = 1'b1;
    @(negedge clk_in);
    n_tests++; if (finish_fetch !== 1'b0) begin n_fail++; $display("FAIL freeze_release got=%b exp=0", finish_fetch); end
  endtask

  task automatic test_reset_mid_miss();
    int fl; logic [31:0] ins, ipc, mpc; bit mr, hold, ex;
    @(negedge clk_in); fetch_start = 1'b1; pc = 32'h40;
    @(negedge clk_in); fetch_start = 1'b0;
    rst_in = 1'b0;
    #1;
    n_tests++; if (mem_fetch_start !== 1'b0 || mem_pc !== 32'h0 || is_idle !== 1'b1 || instruction_out !== 32'h0 || instruction_pc_out !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got mem_start=%b mem_pc=%h idle=%b instr=%h ipc=%h exp 0/0/1/0/0", mem_fetch_start, mem_pc, is_idle, instruction_out, instruction_pc_out);
    end
    cached_pc.delete();
    cached_word.delete();
    @(negedge clk_in); rst_in = 1'b1;
    do_fetch(32'h10, 32'h0010_0002, 2, fl, ins, ipc, mr, mpc, hold, ex);
    model_fill(32'h10, 32'h0010_0002);
    n_tests++; if (mr !== 1'b1 || fl != 3 || ins !== 32'h0010_0002) begin
      n_fail++; $display("FAIL reset_invalidates got_req=%b lat=%0d data=%h exp=1/3/00100002", mr, fl, ins);
    end
  endtask

  task automatic test_random();
    int fl, lat, exp_lat; logic [31:0] a, d, ins, ipc, mpc, exp_d; bit mr, hold, ex, exp_hit;
    for (int i = 0; i < 60; i++) begin
      a   = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
      d   = $urandom;
      lat = $urandom_range(1, 5);
      exp_hit = model_hit(a);
      exp_lat = exp_hit ? 1 : lat + 1;
      exp_d   = exp_hit ? cached_word[line_of(a)] : d;
      do_fetch(a, d, lat, fl, ins, ipc, mr, mpc, hold, ex);
      if (!exp_hit) model_fill(a, d);
      n_tests++; if (fl != exp_lat || mr !== !exp_hit) begin
        n_fail++; $display("FAIL rand_%0d_kind pc=%h got lat=%0d req=%b exp lat=%0d req=%b", i, a, fl, mr, exp_lat, !exp_hit);
      end
      n_tests++; if (ins !== exp_d || ipc !== a) begin
        n_fail++; $display("FAIL rand_%0d_data got=%h@%h exp=%h@%h", i, ins, ipc, exp_d, a);
      end
      n_tests++; if (!hold || ex || (mr && mpc !== a)) begin
        n_fail++; $display("FAIL rand_%0d_proto hold_ok=%b extra=%b mem_pc=%h exp 1/0/%h", i, hold, ex, mpc, a);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_conflict();
    test_roll_back();
    test_freeze();
    test_reset_mid_miss();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's fetch port.
- IF issues fetch requests to this block instead of to the memory controller.
- Hits return in 1 cycle. Misses forward the request to the memory controller, fill the line, then return the word.
- Roll-back aborts an in-flight miss so IF can redirect immediately.

Parameters:
- INDEX_WIDTH, 8, log2 of the number of lines (256 lines, 1 KB of instruction storage).
- ADDR_HI, 17, highest physical address bit used. Tag is pc[ADDR_HI:INDEX_WIDTH+2].

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes all state and outputs.
- roll_back  input  1  branch mispredict flush from IF.
- fetch_start  input  1  IF request valid, 1-cycle pulse.
- pc  input  32  IF request address, word aligned.
- finish_fetch  output  1  1-cycle pulse: instruction_out is valid.
- instruction_out  output  32  fetched instruction word.
- instruction_pc_out  output  32  address of instruction_out.
- mem_fetch_start  output  1  request to the memory controller, held high until mem_finish_fetch.
- mem_pc  output  32  miss address to the memory controller.
- mem_finish_fetch  input  1  memory controller word ready, 1-cycle pulse.
- mem_instruction  input  32  word returned by the memory controller.
- is_idle  output  1  high in IDLE with no pending response.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All valid bits cleared; state=IDLE.
  - finish_fetch=0, mem_fetch_start=0, instruction_out=0, instruction_pc_out=0, mem_pc=0, is_idle=1.
  - Tag and data arrays need no reset.
- Address fields:
  - index = pc[INDEX_WIDTH+1:2]
  - tag = pc[ADDR_HI:INDEX_WIDTH+2]
  - pc[1:0] is ignored.
- Freeze: rdy_in=0 holds all registers, including a pending finish_fetch pulse; the pulse is presented again once rdy_in returns high.
- State IDLE:
  - On fetch_start=1 and roll_back=0, latch pc and compare against the valid/tag of the indexed line.
  - Hit: next cycle finish_fetch=1, instruction_out=data[index], instruction_pc_out=pc; stay in IDLE.
  - Miss: next cycle mem_fetch_start=1, mem_pc=pc; go to MISS.
- State MISS:
  - mem_fetch_start and mem_pc are held stable.
  - On mem_finish_fetch=1: write data[index]=mem_instruction, tag[index]=tag, valid[index]=1.
  - In that same cycle's registered output (next cycle): finish_fetch=1, instruction_out=mem_instruction, instruction_pc_out=latched pc, mem_fetch_start=0; go to IDLE.
- Latency: hit = 1 cycle from fetch_start to finish_fetch; miss = memory latency + 1.
- roll_back=1 (highest priority, any state):
  - Next cycle state=IDLE, mem_fetch_start=0, finish_fetch=0.
  - A fetch_start in the same cycle as roll_back is ignored.
  - No line is written in that cycle, even if mem_finish_fetch is also 1.
- A mem_finish_fetch arriving while in IDLE (late response to an aborted miss) is ignored; no fill happens.
- fetch_start while in MISS is a protocol violation. IF must not issue a request until finish_fetch. The cache ignores it.
- finish_fetch is never high for 2 consecutive cycles with rdy_in=1.
- Conflict misses: same index, different tag overwrites the line, with no write-back (read-only cache).
- is_idle = (state==IDLE) && !mem_fetch_start.

Test Plan:
- Reset, then fetch pc=0x0000_0010; memory returns 0x0000_0013 after 3 cycles -> mem_fetch_start with mem_pc=0x10; one cycle after mem_finish_fetch, finish_fetch=1, instruction_out=0x13, instruction_pc_out=0x10.
- Refetch pc=0x10 -> finish_fetch exactly 1 cycle after fetch_start, data 0x13, mem_fetch_start stays 0.
- Fetch pc=0x410 (same index as 0x10, INDEX_WIDTH=8) returning 0x0000_0093, then refetch 0x10 -> both are misses; 0x10 re-requested from memory and its line refilled.
- Miss on pc=0x20, assert roll_back before mem_finish_fetch, then deliver a late mem_finish_fetch with data 0xDEAD_BEEF -> no finish_fetch; refetch of 0x20 still misses.
- Hit request with rdy_in held low for 4 cycles -> finish_fetch is delayed until rdy_in=1, with unchanged data and pc.
- Assert rst_in low mid-miss -> outputs return to reset values immediately; refetch of a previously cached pc misses.
